alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the ALU interface. It accepts operation commands (ALUctr, A, B) over a valid/ready input channel and buffers them in a small FIFO.
- It drives the combinational ALU one operation at a time, captures Result/Zero, and returns them on a valid/ready response channel.
- It sits between instruction decode and the ALU datapath, and serves as the reusable driver for ALU bring-up.

Parameters:
- DEPTH, 4, number of command FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_ctr  input  3  ALU operation code.
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- alu_ctr  output  3  registered drive to ALU.ALUctr.
- alu_a  output  32  registered drive to ALU.A.
- alu_b  output  32  registered drive to ALU.B.
- alu_result  input  32  ALU.Result (combinational from alu_ctr/a/b).
- alu_zero  input  1  ALU.Zero.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  32  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_err  output  1  operation code was illegal.
- op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Opcodes:
  - 000 add, 001 sub, 010 and, 011 or, 100 slt (signed).
  - 101–111 illegal.
- Reset, synchronous, takes priority over all other activity:
  - FIFO emptied; state IDLE.
  - alu_ctr=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, op_count=0.
  - cmd_ready=1 from the first cycle after reset.
  - An in-flight operation or pending response is discarded without handshake.
- FIFO:
  - cmd_ready = !full, combinational from the count.
  - Push on edge where cmd_valid && cmd_ready.
  - Push and pop on the same edge: both occur and the count is unchanged.
  - When full, cmd_valid is ignored (ready=0).
  - Pointers wrap modulo DEPTH.
  - Commands are issued in strict arrival order.
- State machine (IDLE, ISSUE, RESP):
  - IDLE:
    - FIFO non-empty → pop head into alu_ctr/alu_a/alu_b; go ISSUE.
    - A command pushed into an empty FIFO is not visible to IDLE until the following edge (no bypass).
  - ISSUE: exactly one cycle for the ALU to settle. At the edge:
    - rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_valid<=1; go RESP.
    - If alu_ctr is illegal: rsp_err<=1, rsp_result<=0, rsp_zero<=0.
  - RESP:
    - rsp_* held stable while rsp_valid && !rsp_ready.
    - On edge with rsp_ready=1: op_count increments and rsp_valid<=0.
    - Same edge: if FIFO non-empty, pop the next command into the alu_* registers and go ISSUE; else go IDLE.
- ALU drive registers hold their last value in IDLE; they are not cleared after use.
- Latency:
  - Command accepted at edge E0 into an empty, idle unit: popped at E1, rsp_valid high after E2.
  - Back-to-back throughput with rsp_ready held 1: one response every 2 cycles.
- op_count wraps from 2^CNT_W−1 to 0 with no flag.
- rsp_err is per-response; it is cleared when the next result is captured.

Test Plan:
- Reset, then a single command ctr=000, A=1, B=1; rsp_ready=1 → rsp_valid rises exactly 2 edges after acceptance; rsp_result=2, rsp_zero=0, rsp_err=0; op_count=1.
- Burst of 3 commands: (001, 3, 1), (010, 0, 0), (011, 0, 1) → responses in order: result 2 zero 0; result 0 zero 1; result 1 zero 0. op_count=3. alu_a/b observed changing only on pop edges.
- Backpressure, part 1: rsp_ready=0 while pushing 5 commands (DEPTH=4) → cmd_ready drops to 0 after the FIFO fills. The first response is held stable for ≥10 cycles. The 6th cmd_valid is not accepted.
- Backpressure, part 2: raise rsp_ready → all queued commands drain in order and cmd_ready returns to 1.
- Illegal opcode ctr=101, A=5, B=7 → rsp_err=1, rsp_result=0, rsp_zero=0. A following ctr=000, A=2, B=2 gives rsp_err=0, result 4.
- slt signed: A=0xFFFFFFFF, B=1, ctr=100 → result 1.
- Reset mid-operation: assert reset while in RESP with 2 commands queued → next cycle rsp_valid=0, cmd_ready=1, op_count=0. No stale response appears afterwards.
- op_count wrap (force CNT_W=4 in the bench): 17 completed operations → op_count=1.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issues queued ALU commands one at a time and returns the captured result over a
// valid/ready response channel.
module alu_issue_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_ctr_i,
    input  logic [31:0]      cmd_a_i,
    input  logic [31:0]      cmd_b_i,
    output logic [2:0]       alu_ctr_o,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q;
    logic [2:0]        fifo_ctr_q [DEPTH];
    logic [31:0]       fifo_a_q   [DEPTH];
    logic [31:0]       fifo_b_q   [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;

    logic [2:0]        alu_ctr_q;
    logic [31:0]       alu_a_q, alu_b_q;
    logic              rsp_valid_q, rsp_zero_q, rsp_err_q;
    logic [31:0]       rsp_result_q;
    logic [CNT_W-1:0]  op_count_q;

    logic full, empty, push, pop, illegal;

    always_comb begin
        full    = (count_q == (PtrW + 1)'(DEPTH));
        empty   = (count_q == '0);
        push    = cmd_valid_i && !full;
        // Pop happens exactly where the FSM loads the next command.
        pop     = !empty && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready_i));
        illegal = (alu_ctr_q > 3'd4);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_ctr_q[wr_ptr_q] <= cmd_ctr_i;
            fifo_a_q[wr_ptr_q]   <= cmd_a_i;
            fifo_b_q[wr_ptr_q]   <= cmd_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            alu_ctr_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        alu_ctr_q <= fifo_ctr_q[rd_ptr_q];
                        alu_a_q   <= fifo_a_q[rd_ptr_q];
                        alu_b_q   <= fifo_b_q[rd_ptr_q];
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= illegal;
                    if (illegal) begin
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b0;
                    end else begin
                        rsp_result_q <= alu_result_i;
                        rsp_zero_q   <= alu_zero_i;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        if (!empty) begin
                            alu_ctr_q <= fifo_ctr_q[rd_ptr_q];
                            alu_a_q   <= fifo_a_q[rd_ptr_q];
                            alu_b_q   <= fifo_b_q[rd_ptr_q];
                            state_q   <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o  = !full;
    assign alu_ctr_o    = alu_ctr_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_err_o    = rsp_err_q;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU; CNT_W shrunk to 4 to
// reach the counter wrap quickly.
module tb_alu_issue_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_ctr;
    logic [31:0]      cmd_a, cmd_b;
    logic [2:0]       alu_ctr;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [31:0]      rsp_result;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ctr_i(cmd_ctr), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .alu_ctr_o(alu_ctr), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
        .op_count_o(op_count)
    );

    // Illegal codes drive garbage and zero=1 so a missing err override is visible.
    always_comb begin
        case (alu_ctr)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_ctr > 3'd4) ? 1'b1 : (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_ctr   = c;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] res, input logic z,
                        input logic e);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_ctr = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_op_count", {28'd0, op_count}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctr", {29'd0, alu_ctr}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Single add: valid two edges after acceptance.
        rsp_ready = 1'b1;
        push(3'd0, 32'd1, 32'd1);
        chk("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("lat_e1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_e1_alu_a", alu_a, 32'd1);
        tick();
        chk("lat_e2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lat_result", rsp_result, 32'd2);
        chk("lat_zero", {31'd0, rsp_zero}, 32'd0);
        chk("lat_err", {31'd0, rsp_err}, 32'd0);
        tick();
        chk("lat_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_op_count", {28'd0, op_count}, 32'd1);
        rsp_ready = 1'b0;

        // Burst of three.
        push(3'd1, 32'd3, 32'd1);
        push(3'd2, 32'd0, 32'd0);
        push(3'd3, 32'd0, 32'd1);
        chk("burst_first_valid", {31'd0, rsp_valid}, 32'd1);
        chk("burst_alu_a_hold", alu_a, 32'd3);
        chk("burst_alu_b_hold", alu_b, 32'd1);
        tick();
        chk("burst_alu_a_stable", alu_a, 32'd3);
        take("burst0", 32'd2, 1'b0, 1'b0);
        chk("burst_alu_a_pop", alu_a, 32'd0);
        chk("burst_alu_b_pop", alu_b, 32'd0);
        take("burst1", 32'd0, 1'b1, 1'b0);
        take("burst2", 32'd1, 1'b0, 1'b0);
        chk("burst_op_count", {28'd0, op_count}, 32'd4);

        // Backpressure: fill the FIFO behind a stalled response.
        push(3'd0, 32'd10, 32'd1);
        push(3'd0, 32'd20, 32'd2);
        push(3'd1, 32'd5, 32'd5);
        push(3'd3, 32'hF0, 32'h0F);
        push(3'd2, 32'hFF, 32'h0F);
        cmd_valid = 1'b1; cmd_ctr = 3'd0; cmd_a = 32'd100; cmd_b = 32'd100;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd11);
            tick();
        end
        cmd_valid = 1'b0;
        take("bp0", 32'd11, 1'b0, 1'b0);
        take("bp1", 32'd22, 1'b0, 1'b0);
        take("bp2", 32'd0, 1'b1, 1'b0);
        take("bp3", 32'hFF, 1'b0, 1'b0);
        take("bp4", 32'h0F, 1'b0, 1'b0);
        chk("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_no_sixth", {31'd0, rsp_valid}, 32'd0);
        end
        chk("bp_op_count", {28'd0, op_count}, 32'd9);

        // Illegal opcode, then recovery; signed slt.
        push(3'd5, 32'd5, 32'd7);
        push(3'd0, 32'd2, 32'd2);
        take("illegal", 32'd0, 1'b0, 1'b1);
        take("after_illegal", 32'd4, 1'b0, 1'b0);
        push(3'd4, 32'hFFFF_FFFF, 32'd1);
        push(3'd4, 32'd1, 32'hFFFF_FFFF);
        take("slt_neg", 32'd1, 1'b0, 1'b0);
        take("slt_pos", 32'd0, 1'b1, 1'b0);
        chk("mid_op_count", {28'd0, op_count}, 32'd13);

        // Reset while a response is pending and two commands are queued.
        push(3'd0, 32'd1, 32'd2);
        push(3'd0, 32'd3, 32'd4);
        push(3'd0, 32'd5, 32'd6);
        chk("mr_pending", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mr_op_count", {28'd0, op_count}, 32'd0);
        chk("mr_alu_a", alu_a, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mr_no_stale", {31'd0, rsp_valid}, 32'd0);
        end
        rsp_ready = 1'b0;

        // Counter wrap with a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            push(3'd0, 32'(i), 32'd1);
            take("wrap", 32'(i + 1), 1'b0, 1'b0);
            if (i == 15) chk("wrap_zero", {28'd0, op_count}, 32'd0);
        end
        chk("wrap_one", {28'd0, op_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
